// File: rtl/wb_stage_pkg.sv
// Shared encodings and widths for the writeback stage and its helpers.
package wb_stage_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_LINK = 2'd2,
    WD_CP0  = 2'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } load_type_e;

endpackage

// File: rtl/wb_stage_if.sv
// M-stage result bundle into W, and the GRF/forwarding/trace outputs out of W.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic              flush;
  logic              m_valid;
  logic [DATA_W-1:0] m_pc;
  logic              m_rf_we;
  logic [REG_W-1:0]  m_rf_a3;
  logic [1:0]        m_wd_sel;
  logic [2:0]        m_load_type;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_mem_rdata;
  logic [DATA_W-1:0] m_cp0_rdata;

  logic              grf_we;
  logic [REG_W-1:0]  grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] w_pc;
  logic              w_valid;
  logic [DATA_W-1:0] instret;

  modport master (
    output flush, m_valid, m_pc, m_rf_we, m_rf_a3, m_wd_sel, m_load_type,
           m_alu_result, m_mem_rdata, m_cp0_rdata,
    input  grf_we, grf_a3, grf_wd, w_pc, w_valid, instret
  );

  modport slave (
    input  flush, m_valid, m_pc, m_rf_we, m_rf_a3, m_wd_sel, m_load_type,
           m_alu_result, m_mem_rdata, m_cp0_rdata,
    output grf_we, grf_a3, grf_wd, w_pc, w_valid, instret
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Load data formatter: picks the byte/halfword lane from a raw little-endian word and extends it.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]        load_type,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = raw[7:0];
    case (offset)
      2'd0: byte_lane = raw[7:0];
      2'd1: byte_lane = raw[15:8];
      2'd2: byte_lane = raw[23:16];
      2'd3: byte_lane = raw[31:24];
      default: byte_lane = raw[7:0];
    endcase
    // offset[0] is ignored for halfwords; misalignment traps before W
    half_lane = offset[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = raw;
    case (load_type)
      LD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      LD_LBU:  data = {24'd0, byte_lane};
      LD_LH:   data = {{16{half_lane[15]}}, half_lane};
      LD_LHU:  data = {16'd0, half_lane};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the M-stage bundle, drives the GRF write port and counts retirements.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);

  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic              rf_we_q;
  logic [REG_W-1:0]  a3_q;
  wd_sel_e           wd_sel_q;
  logic [2:0]        load_type_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] cp0_q;
  logic [DATA_W-1:0] instret_q;

  logic              we;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wd;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      valid_q     <= 1'b0;
      pc_q        <= RESET_PC;
      rf_we_q     <= 1'b0;
      a3_q        <= '0;
      wd_sel_q    <= WD_ALU;
      load_type_q <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      cp0_q       <= '0;
    end else begin
      valid_q     <= bus.m_valid;
      pc_q        <= bus.m_pc;
      rf_we_q     <= bus.m_rf_we;
      a3_q        <= bus.m_rf_a3;
      wd_sel_q    <= wd_sel_e'(bus.m_wd_sel);
      load_type_q <= bus.m_load_type;
      alu_q       <= bus.m_alu_result;
      mem_q       <= bus.m_mem_rdata;
      cp0_q       <= bus.m_cp0_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (!bus.flush && bus.m_valid) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  load_ext u_load_ext (
    .load_type (load_type_q),
    .offset    (alu_q[1:0]),
    .raw       (mem_q),
    .data      (load_data)
  );

  assign we = valid_q && rf_we_q && (a3_q != '0);

  always_comb begin
    wd = '0;
    if (we) begin
      case (wd_sel_q)
        WD_ALU:  wd = alu_q;
        WD_MEM:  wd = load_data;
        WD_LINK: wd = pc_q + 32'd8;
        WD_CP0:  wd = cp0_q;
        default: wd = '0;
      endcase
    end
  end

  assign bus.grf_we  = we;
  assign bus.grf_a3  = we ? a3_q : '0;
  assign bus.grf_wd  = wd;
  assign bus.w_pc    = pc_q;
  assign bus.w_valid = valid_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected W outputs, a monitor pops and compares.
module tb_wb_stage;

  logic clk;
  logic reset;

  wb_stage_if bus ();

  wb_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] model_cnt = '0;

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%08h required=%08h", name, field, act, req);
    end
  endtask

  // Monitor: W outputs are valid every cycle, so compare one entry per edge when one is pending
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "grf_we",  {31'd0, bus.grf_we},  {31'd0, e.we});
        check(e.name, "grf_a3",  {27'd0, bus.grf_a3},  {27'd0, e.a3});
        check(e.name, "grf_wd",  bus.grf_wd,           e.wd);
        check(e.name, "w_pc",    bus.w_pc,             e.pc);
        check(e.name, "w_valid", {31'd0, bus.w_valid}, {31'd0, e.valid});
        check(e.name, "instret", bus.instret,          e.cnt);
      end
    end
  end

  task automatic cyc(input string name, input logic rst, input logic fl, input logic v,
                     input logic [31:0] pc, input logic we, input logic [4:0] a3,
                     input logic [1:0] sel, input logic [2:0] lt, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] cp0,
                     input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                     input logic [31:0] epc, input logic evalid);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    bus.flush        = fl;
    bus.m_valid      = v;
    bus.m_pc         = pc;
    bus.m_rf_we      = we;
    bus.m_rf_a3      = a3;
    bus.m_wd_sel     = sel;
    bus.m_load_type  = lt;
    bus.m_alu_result = alu;
    bus.m_mem_rdata  = mem;
    bus.m_cp0_rdata  = cp0;
    if (rst) model_cnt = '0;
    else if (!fl && v) model_cnt = model_cnt + 32'd1;
    e.name = name; e.we = ewe; e.a3 = ea3; e.wd = ewd; e.pc = epc; e.valid = evalid;
    e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  localparam logic [31:0] RW = 32'h8081_F27F;
  localparam logic [31:0] BA = 32'h1000_0000;

  initial begin
    int unsigned waited;
    reset = 1'b1;
    bus.flush = 1'b0; bus.m_valid = 1'b0; bus.m_pc = '0; bus.m_rf_we = 1'b0;
    bus.m_rf_a3 = '0; bus.m_wd_sel = '0; bus.m_load_type = '0;
    bus.m_alu_result = '0; bus.m_mem_rdata = '0; bus.m_cp0_rdata = '0;

    //   name        rst fl v  pc            we a3  sel  lt    alu            mem  cp0             ewe ea3 ewd            epc           ev
    cyc("rst0",      1, 0, 1, 32'h0000_4000, 1, 5,  0, 0, 32'h1111_1111, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3000, 0);
    cyc("rst1",      1, 0, 1, 32'h0000_4004, 1, 6,  0, 0, 32'h2222_2222, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3000, 0);
    cyc("alu",       0, 0, 1, 32'h0000_3000, 1, 8,  0, 0, 32'h1234_5678, RW, 32'h0,            1, 8,  32'h1234_5678, 32'h0000_3000, 1);
    cyc("alu_r0",    0, 0, 1, 32'h0000_3004, 1, 0,  0, 0, 32'h1234_5678, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3004, 1);
    cyc("lb0",       0, 0, 1, 32'h0000_3008, 1, 9,  1, 1, BA + 0,        RW, 32'h0,            1, 9,  32'h0000_007F, 32'h0000_3008, 1);
    cyc("lb1",       0, 0, 1, 32'h0000_300C, 1, 9,  1, 1, BA + 1,        RW, 32'h0,            1, 9,  32'hFFFF_FFF2, 32'h0000_300C, 1);
    cyc("lb2",       0, 0, 1, 32'h0000_3010, 1, 9,  1, 1, BA + 2,        RW, 32'h0,            1, 9,  32'hFFFF_FF81, 32'h0000_3010, 1);
    cyc("lb3",       0, 0, 1, 32'h0000_3014, 1, 9,  1, 1, BA + 3,        RW, 32'h0,            1, 9,  32'hFFFF_FF80, 32'h0000_3014, 1);
    cyc("lbu2",      0, 0, 1, 32'h0000_3018, 1, 10, 1, 2, BA + 2,        RW, 32'h0,            1, 10, 32'h0000_0081, 32'h0000_3018, 1);
    cyc("lh0",       0, 0, 1, 32'h0000_301C, 1, 11, 1, 3, BA + 0,        RW, 32'h0,            1, 11, 32'hFFFF_F27F, 32'h0000_301C, 1);
    cyc("lhu2",      0, 0, 1, 32'h0000_3020, 1, 11, 1, 4, BA + 2,        RW, 32'h0,            1, 11, 32'h0000_8081, 32'h0000_3020, 1);
    cyc("lh3",       0, 0, 1, 32'h0000_3024, 1, 11, 1, 3, BA + 3,        RW, 32'h0,            1, 11, 32'hFFFF_8081, 32'h0000_3024, 1);
    cyc("lw1",       0, 0, 1, 32'h0000_3028, 1, 12, 1, 0, BA + 1,        RW, 32'h0,            1, 12, 32'h8081_F27F, 32'h0000_3028, 1);
    cyc("ld_undef",  0, 0, 1, 32'h0000_302C, 1, 12, 1, 7, BA + 2,        RW, 32'h0,            1, 12, 32'h8081_F27F, 32'h0000_302C, 1);
    cyc("cp0",       0, 0, 1, 32'h0000_3030, 1, 13, 3, 0, 32'h0,         RW, 32'hDEAD_BEEF,    1, 13, 32'hDEAD_BEEF, 32'h0000_3030, 1);
    cyc("link",      0, 0, 1, 32'h0000_3010, 1, 31, 2, 0, 32'h0,         RW, 32'h0,            1, 31, 32'h0000_3018, 32'h0000_3010, 1);
    cyc("link_wrap", 0, 0, 1, 32'hFFFF_FFFC, 1, 31, 2, 0, 32'h0,         RW, 32'h0,            1, 31, 32'h0000_0004, 32'hFFFF_FFFC, 1);
    cyc("no_we",     0, 0, 1, 32'h0000_3034, 0, 14, 0, 0, 32'h5555_AAAA, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3034, 1);
    cyc("invalid",   0, 0, 0, 32'h0000_3038, 1, 14, 0, 0, 32'h5555_AAAA, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3038, 0);
    cyc("flush",     0, 1, 1, 32'h0000_303C, 1, 9,  0, 0, 32'h7777_7777, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3000, 0);
    cyc("after_fl",  0, 0, 1, 32'h0000_3040, 1, 9,  0, 0, 32'h0BAD_F00D, RW, 32'h0,            1, 9,  32'h0BAD_F00D, 32'h0000_3040, 1);
    cyc("rst_fl",    1, 1, 1, 32'h0000_3044, 1, 9,  0, 0, 32'h0BAD_F00D, RW, 32'h0,            0, 0,  32'h0,         32'h0000_3000, 0);
    cyc("post_rst",  0, 0, 1, 32'h0000_3048, 1, 3,  0, 0, 32'hCAFE_0001, RW, 32'h0,            1, 3,  32'hCAFE_0001, 32'h0000_3048, 1);

    // Preload the counter just below wrap between edges, then retire once more
    @(posedge clk);
    #2;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_cnt = 32'hFFFF_FFFF;
    cyc("wrap",      0, 0, 1, 32'h0000_304C, 1, 4,  0, 0, 32'h0000_0042, RW, 32'h0,            1, 4,  32'h0000_0042, 32'h0000_304C, 1);
    cyc("wrap_next", 0, 0, 1, 32'h0000_3050, 1, 4,  0, 0, 32'h0000_0043, RW, 32'h0,            1, 4,  32'h0000_0043, 32'h0000_3050, 1);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipelined MIPS core. It captures the Memory-stage result bundle on each clock and formats load data, selecting among ALU, memory, link (PC+8) and CP0 read results. It drives the GRF write port (write-enable, destination address, write data) and mirrors the same value to the forwarding network. It also keeps a retired-instruction counter for debug and trace.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: value of `w_pc` after reset and for bubbles.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  exception/eret flush; the captured slot becomes a bubble.
- `m_valid`  in  1  M-stage slot holds a real instruction.
- `m_pc`  in  32  PC of the M-stage instruction.
- `m_rf_we`  in  1  instruction writes the GRF.
- `m_rf_a3`  in  5  destination register.
- `m_wd_sel`  in  2  `WD_ALU`=0, `WD_MEM`=1, `WD_LINK`=2, `WD_CP0`=3.
- `m_load_type`  in  3  `LD_LW`=0, `LD_LB`=1, `LD_LBU`=2, `LD_LH`=3, `LD_LHU`=4.
- `m_alu_result`  in  32  ALU result; also the load address.
- `m_mem_rdata`  in  32  raw word read from data memory.
- `m_cp0_rdata`  in  32  mfc0 read data.
- `grf_we`  out  1  GRF write enable.
- `grf_a3`  out  5  GRF write address.
- `grf_wd`  out  32  GRF write data.
- `w_pc`  out  32  PC of the W-stage instruction.
- `w_valid`  out  1  W slot holds a retiring instruction.
- `instret`  out  32  count of retired instructions.

## Operation
- One pipeline register set (valid, pc, rf_we, a3, wd_sel, load_type, alu_result, mem_rdata, cp0_rdata) loads on every posedge. There is no stall, because W never stalls.
- Capture rule: `reset` takes priority, then `flush`, then a normal load.
  - `reset`: all fields 0, pc=`RESET_PC`.
  - `flush`: valid=0, rf_we=0, pc=`RESET_PC`; data fields don't-care but are cleared.
  - Normal load: fields take the M-stage values.
- `grf_we` = valid & rf_we & (a3 != 0). A write to $0 is never issued.
- `grf_a3` = a3 when `grf_we` is high, otherwise 0.
- `grf_wd` by wd_sel:
  - ALU: alu_result.
  - MEM: formatted load data.
  - LINK: pc + 8, modulo 2^32.
  - CP0: cp0_rdata.
  - When `grf_we`=0, `grf_wd` is 0.
- Load formatting uses byte offset `alu_result[1:0]`, little-endian byte lanes:
  - LB/LBU: byte lane `[8*off+7 : 8*off]`, sign- or zero-extended.
  - LH/LHU: halfword `alu_result[1]` selects the upper or lower halfword, sign- or zero-extended. `alu_result[0]` is ignored, because alignment faults are raised upstream.
  - LW and undefined codes (5-7): full word.
- `instret` increments by 1 on every posedge where a valid, unflushed instruction is captured (reset=0, flush=0, m_valid=1). It wraps from FFFF_FFFF to 0 and is cleared by reset.

## Timing
- Latency: M-stage inputs sampled at edge N appear on `grf_*` and `w_*` after edge N. The GRF commits at edge N+1; its internal write-through makes the value visible to D-stage reads during cycle N.
- All outputs are combinational from the pipeline register only; there is no input-to-output combinational path.
- Reset values: `grf_we`=0, `grf_a3`=0, `grf_wd`=0, `w_valid`=0, `w_pc`=`RESET_PC`, `instret`=0.
- `flush` asserted at edge N: the cycle after N shows a bubble, and `instret` is unchanged.
- `reset` and `flush` together: reset wins.
- Reset mid-stream: the in-flight W instruction is discarded and never written.

## Structure
- `defines.v` (shared, included) holds:
  - `WD_*` and `LD_*` encodings;
  - `RESET_PC` default;
  - register-index width (5) and data width (32).
- One sub-module `load_ext` (combinational: load_type, offset, raw word -> formatted word) is natural. The M stage also reuses it for store-data checks.

## Test plan
- Reset, then hold `reset` 2 cycles with m_valid=1 inputs -> grf_we=0, w_pc=0000_3000, instret=0.
- ALU writeback: m_rf_a3=8, wd_sel=ALU, alu_result=1234_5678 -> next cycle grf_we=1, a3=8, wd=1234_5678, instret=1. Same with a3=0 -> grf_we=0, instret still increments.
- Loads: mem_rdata=8081_F27F, addr offsets 0-3.
  - LB: 0000_007F, FFFF_FFF2, FFFF_FF81, FFFF_FF80.
  - LBU offset 2: 0000_0081.
  - LH offset 0: FFFF_F27F.
  - LHU offset 2: 0000_8081.
  - LH offset 3: FFFF_8081.
- Link: pc=0000_3010, wd_sel=LINK, a3=31 -> wd=0000_3018. pc=FFFF_FFFC -> wd=0000_0004.
- Flush: `flush` on the edge capturing a valid write to $9 -> grf_we=0, w_valid=0, instret unchanged. `flush` and `reset` together -> reset values.
- Counter wrap: preload via 2^32-1 retirements (or force) -> the next retirement yields instret=0.
